// File: rtl/multi_mem_port_if.sv
// Core-side request/response bundle for multi_mem_port.
// Ports (master = datapath, slave = multi_mem_port):
//   req, we, addr[31:0], wdata[31:0]   master -> slave
//   rdata[31:0], ready, busy, err      slave -> master
interface multi_mem_port_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;
   logic              err;

   modport master (output req, we, addr, wdata, input rdata, ready, busy, err);
   modport slave  (input req, we, addr, wdata, output rdata, ready, busy, err);
endinterface

// File: rtl/multi_mem_port.sv
// Single-port word memory interface between the multi-cycle core and a BRAM
// with fixed read latency RD_LAT (1..4). One access at a time, no queueing.
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   bus (slave)       req/we/addr/wdata in; rdata/ready/busy/err out
//   bram_en/we/addr/din out, bram_dout in   BRAM port
// Optional: define MULTI_MEM_ALIGN_CHECK_EN to reject requests with
// addr[1:0] != 0 (no BRAM access, ready+err pulse). Otherwise err is 0.
module multi_mem_port #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   multi_mem_port_if.slave       bus,
   output logic                  bram_en,
   output logic [3:0]            bram_we,
   output logic [DEPTH_LOG2-1:0] bram_addr,
   output logic [31:0]           bram_din,
   input  logic [31:0]           bram_dout
);
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, DONE} state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [31:0]           rdata_q, rdata_nxt;
   logic                  ready_q, ready_nxt;
   logic                  busy_q, busy_nxt;
   logic                  bram_en_nxt;
   logic [3:0]            bram_we_nxt;
   logic [DEPTH_LOG2-1:0] bram_addr_nxt;
   logic [31:0]           bram_din_nxt;
   logic                  misaligned;
   logic                  unused_addr_bits;

`ifdef MULTI_MEM_ALIGN_CHECK_EN
   logic err_q, err_nxt;
   logic err_pend, err_pend_nxt;

   assign misaligned       = (bus.addr[1:0] != 2'b00);
   assign unused_addr_bits = ^bus.addr[31:DEPTH_LOG2+2];
   assign bus.err          = err_q;
`else
   assign misaligned       = 1'b0;
   assign unused_addr_bits = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};
   assign bus.err          = 1'b0;
`endif

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      rdata_nxt     = rdata_q;
      ready_nxt     = 1'b0;
      bram_en_nxt   = 1'b0;
      bram_we_nxt   = 4'h0;
      bram_addr_nxt = bram_addr;
      bram_din_nxt  = bram_din;
`ifdef MULTI_MEM_ALIGN_CHECK_EN
      err_nxt       = 1'b0;
      err_pend_nxt  = err_pend;
`endif
      unique case (state)
         IDLE: begin
            if (bus.req) begin
               if (misaligned) begin
                  // Rejected access reuses WRITE to time the ready/err pulse.
`ifdef MULTI_MEM_ALIGN_CHECK_EN
                  err_pend_nxt = 1'b1;
`endif
                  state_nxt = WRITE;
               end else begin
`ifdef MULTI_MEM_ALIGN_CHECK_EN
                  err_pend_nxt = 1'b0;
`endif
                  bram_addr_nxt = bus.addr[DEPTH_LOG2+1:2];
                  bram_din_nxt  = bus.wdata;
                  bram_en_nxt   = 1'b1;
                  bram_we_nxt   = bus.we ? 4'hF : 4'h0;
                  if (bus.we) begin
                     state_nxt = WRITE;
                  end else begin
                     state_nxt = READ_WAIT;
                     cnt_nxt   = CNT_W'(RD_LAT);
                  end
               end
            end
         end
         WRITE: begin
            ready_nxt = 1'b1;
`ifdef MULTI_MEM_ALIGN_CHECK_EN
            err_nxt   = err_pend;
`endif
            state_nxt = DONE;
         end
         READ_WAIT: begin
            // Counter expires on the edge where bram_dout is valid.
            if (cnt == CNT_W'(0)) begin
               rdata_nxt = bram_dout;
               ready_nxt = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         bram_en   <= 1'b0;
         bram_we   <= 4'h0;
         bram_addr <= '0;
         bram_din  <= '0;
`ifdef MULTI_MEM_ALIGN_CHECK_EN
         err_q     <= 1'b0;
         err_pend  <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rdata_q   <= rdata_nxt;
         ready_q   <= ready_nxt;
         busy_q    <= busy_nxt;
         bram_en   <= bram_en_nxt;
         bram_we   <= bram_we_nxt;
         bram_addr <= bram_addr_nxt;
         bram_din  <= bram_din_nxt;
`ifdef MULTI_MEM_ALIGN_CHECK_EN
         err_q     <= err_nxt;
         err_pend  <= err_pend_nxt;
`endif
      end
   end
endmodule
